multicycle_ctrl: RTL and testbench

Multicycle successor to the single-cycle main control decoder. A Moore state machine sequences each instruction over 3–5 cycles: fetch, decode, execute/address, memory, write-back. It drives the datapath enables and muxes of the shared-ALU, single-memory multicycle datapath. It adds an optional memory-ready handshake, a run gate, an instruction-complete pulse, and a sticky trap on unsupported opcodes.

---
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared-ALU, single-memory multicycle datapath.
// Sequences fetch/decode/execute/memory/write-back, with optional memory-ready waits.
module multicycle_ctrl #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned ADDI_EN       = 1,
  parameter int unsigned STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               run,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_q;
  state_t state_d;
  logic   mem_ok;
  logic   fetch_ok;

  assign mem_ok   = (MEM_HANDSHAKE == 0) || mem_ready;
  assign fetch_ok = run && mem_ok;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = fetch_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = (ADDI_EN != 0) ? S_ADDIEX : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Decode is gated by reset directly so every control is low while reset is held.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = fetch_ok;
          pcwrite = fetch_ok;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          memwrite   = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ok;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          pcwrite    = 1'b1;
          pcsource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ADDIWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    end
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: hand-written vector table, corner sequences, and
// randomized run against a plan-based reference model on three configurations.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       run;
    logic       rdy;
    logic [3:0] st;
    logic       done;
    logic       ill;
    logic       mr;
    logic [3:0] we;
  } vec_t;

  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04;
  localparam logic [5:0] J = 6'h02, ADDI = 6'h08, BAD = 6'h3F;
  localparam logic [2:0] HS_P   = 3'b011;
  localparam logic [2:0] ADDI_P = 3'b101;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       mem_ready;
  logic [5:0] opc    [3];
  ctl_t       got    [3];
  logic [5:0] st_got [3];

  int n_vec = 0;
  int n_bad = 0;

  int plan [3][6];
  int plen [3];
  int pidx [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int SW_W = (gi == 2) ? 6 : 4;
      logic pcwrite_w, pcwritecond_w, iord_w, memread_w, memwrite_w, irwrite_w;
      logic memtoreg_w, regdst_w, regwrite_w, alusrca_w, instr_done_w, illegal_w;
      logic [1:0] alusrcb_w, aluop_w, pcsource_w;
      logic [SW_W-1:0] state_w;

      multicycle_ctrl #(
        .MEM_HANDSHAKE(int'(HS_P[gi])),
        .ADDI_EN      (int'(ADDI_P[gi])),
        .STATE_W      (SW_W)
      ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opc[gi]),
        .run        (run),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite_w),
        .pcwritecond(pcwritecond_w),
        .iord       (iord_w),
        .memread    (memread_w),
        .memwrite   (memwrite_w),
        .irwrite    (irwrite_w),
        .memtoreg   (memtoreg_w),
        .regdst     (regdst_w),
        .regwrite   (regwrite_w),
        .alusrca    (alusrca_w),
        .alusrcb    (alusrcb_w),
        .aluop      (aluop_w),
        .pcsource   (pcsource_w),
        .instr_done (instr_done_w),
        .illegal    (illegal_w),
        .state      (state_w)
      );

      assign got[gi] = {pcwrite_w, pcwritecond_w, iord_w, memread_w, memwrite_w, irwrite_w,
                        memtoreg_w, regdst_w, regwrite_w, alusrca_w, alusrcb_w, aluop_w,
                        pcsource_w, instr_done_w, illegal_w};
      assign st_got[gi] = 6'(state_w);
    end
  endgenerate

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_op(logic [5:0] op);
    for (int k = 0; k < 3; k++) opc[k] = op;
  endtask

  // Reference model: an instruction is a list of state codes chosen at fetch.
  function automatic int mstate(int k);
    return (pidx[k] == 0) ? 0 : plan[k][pidx[k]];
  endfunction

  task automatic load_plan(int k, logic [5:0] op);
    plan[k][0] = 0;
    plan[k][1] = 1;
    case (op)
      LW:   begin plan[k][2] = 2; plan[k][3] = 3; plan[k][4] = 4; plen[k] = 5; end
      SW:   begin plan[k][2] = 2; plan[k][3] = 5; plen[k] = 4; end
      R:    begin plan[k][2] = 6; plan[k][3] = 7; plen[k] = 4; end
      BEQ:  begin plan[k][2] = 8; plen[k] = 3; end
      J:    begin plan[k][2] = 9; plen[k] = 3; end
      ADDI: begin
        if (ADDI_P[k]) begin plan[k][2] = 10; plan[k][3] = 11; plen[k] = 4; end
        else begin plan[k][2] = 12; plen[k] = 3; end
      end
      default: begin plan[k][2] = 12; plen[k] = 3; end
    endcase
  endtask

  function automatic logic mem_ok(int k);
    return (HS_P[k] == 1'b0) || (mem_ready == 1'b1);
  endfunction

  function automatic ctl_t exp_ctl(int k);
    ctl_t e;
    e = '0;
    if (reset) return e;
    case (mstate(k))
      0: begin
        e.memread = 1'b1; e.alusrcb = 2'b01;
        if (run && mem_ok(k)) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
      end
      1: e.alusrcb = 2'b11;
      2: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      3: begin e.memread = 1'b1; e.iord = 1'b1; end
      4: begin e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1; end
      5: begin e.memwrite = 1'b1; e.iord = 1'b1; e.instr_done = mem_ok(k); end
      6: begin e.alusrca = 1'b1; e.aluop = 2'b10; end
      7: begin e.regwrite = 1'b1; e.regdst = 1'b1; e.instr_done = 1'b1; end
      8: begin
        e.alusrca = 1'b1; e.aluop = 2'b01; e.pcwritecond = 1'b1;
        e.pcsource = 2'b01; e.instr_done = 1'b1;
      end
      9: begin e.pcwrite = 1'b1; e.pcsource = 2'b10; e.instr_done = 1'b1; end
      10: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      11: begin e.regwrite = 1'b1; e.instr_done = 1'b1; end
      12: e.illegal = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic model_step(int k);
    int s;
    s = mstate(k);
    if (s == 0) begin
      if (run && mem_ok(k)) begin
        load_plan(k, opc[k]);
        pidx[k] = 1;
      end
    end else if (!(s == 12 || ((s == 3 || s == 5) && !mem_ok(k)))) begin
      pidx[k]++;
      if (pidx[k] >= plen[k]) pidx[k] = 0;
    end
  endtask

  task automatic model_check(int k);
    ctl_t e;
    e = exp_ctl(k);
    n_vec++;
    if (got[k] !== e || st_got[k] !== 6'(mstate(k))) begin
      n_bad++;
      $display("FAIL rand dut%0d: state %0d ctl %h, expected state %0d ctl %h",
               k, st_got[k], got[k], mstate(k), e);
    end
  endtask

  function automatic logic [5:0] pick_op();
    int r;
    r = $urandom_range(0, 15);
    if (r < 3) return R;
    if (r < 5) return LW;
    if (r < 7) return SW;
    if (r < 9) return BEQ;
    if (r < 11) return J;
    if (r < 14) return ADDI;
    return 6'($urandom_range(0, 63));
  endfunction

  vec_t tbl [$];

  task automatic add(logic rst, logic [5:0] op, logic rn, logic rdy, logic [3:0] st,
                     logic done, logic ill, logic mr, logic [3:0] we);
    tbl.push_back({rst, op, rn, rdy, st, done, ill, mr, we});
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1;
    set_op(R);

    // we = {pcwrite, irwrite, regwrite, memwrite}
    add(1, R, 1, 1, 0, 0, 0, 0, 4'b0000);
    add(0, R, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, R, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(0, R, 1, 1, 6, 0, 0, 0, 4'b0000);
    add(0, R, 1, 1, 7, 1, 0, 0, 4'b0010);
    add(0, LW, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, LW, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(0, LW, 1, 1, 2, 0, 0, 0, 4'b0000);
    add(0, LW, 1, 0, 3, 0, 0, 1, 4'b0000);
    add(0, LW, 1, 0, 3, 0, 0, 1, 4'b0000);
    add(0, LW, 1, 1, 3, 0, 0, 1, 4'b0000);
    add(0, LW, 1, 1, 4, 1, 0, 0, 4'b0010);
    add(0, BEQ, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, BEQ, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(0, BEQ, 1, 1, 8, 1, 0, 0, 4'b0000);
    add(0, J, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, J, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(0, J, 1, 1, 9, 1, 0, 0, 4'b1000);
    for (int i = 0; i < 4; i++) add(0, SW, 0, 1, 0, 0, 0, 1, 4'b0000);
    add(0, SW, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, SW, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(0, SW, 1, 1, 2, 0, 0, 0, 4'b0000);
    add(0, SW, 1, 0, 5, 0, 0, 0, 4'b0001);
    add(0, SW, 1, 1, 5, 1, 0, 0, 4'b0001);
    add(0, ADDI, 1, 0, 0, 0, 0, 1, 4'b0000);
    add(0, ADDI, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, ADDI, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(0, ADDI, 1, 1, 10, 0, 0, 0, 4'b0000);
    add(0, ADDI, 1, 1, 11, 1, 0, 0, 4'b0010);
    add(0, BAD, 1, 1, 0, 0, 0, 1, 4'b1100);
    add(0, BAD, 1, 1, 1, 0, 0, 0, 4'b0000);
    add(0, BAD, 1, 1, 12, 0, 1, 0, 4'b0000);
    add(0, BAD, 1, 0, 12, 0, 1, 0, 4'b0000);
    add(1, BAD, 1, 1, 0, 0, 0, 0, 4'b0000);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; set_op(tbl[i].op); run = tbl[i].run; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          int'({st_got[0], got[0].instr_done, got[0].illegal, got[0].memread,
                got[0].pcwrite, got[0].irwrite, got[0].regwrite, got[0].memwrite}),
          int'({2'b00, tbl[i].st, tbl[i].done, tbl[i].ill, tbl[i].mr, tbl[i].we}));
    end

    // addi on the ADDI_EN=0 instance must trap and stay trapped until reset
    @(negedge clk); reset = 1'b0; set_op(ADDI); run = 1'b1; mem_ready = 1'b1; #1;
    chk("noaddi_fetch", int'(st_got[1]), 0);
    @(negedge clk); #1;
    chk("noaddi_decode", int'(st_got[1]), 1);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
      chk($sformatf("trap_hold%0d", i),
          int'({st_got[1], got[1].illegal, got[1].pcwrite, got[1].pcwritecond, got[1].irwrite,
                got[1].regwrite, got[1].memwrite, got[1].instr_done}),
          int'({6'd12, 7'b1000000}));
    end
    @(negedge clk); reset = 1'b1; #1;
    chk("trap_reset", int'({st_got[1], got[1].illegal}), 0);

    // asynchronous reset in the middle of a stalled store
    @(negedge clk); reset = 1'b0; set_op(SW); mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("memwr_stall", int'({st_got[0], got[0].memwrite}), int'({6'd5, 1'b1}));
    #2 reset = 1'b1; #1;
    chk("async_reset", int'({st_got[0], got[0].memwrite, got[0].iord}), 0);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
    chk("after_reset", int'({st_got[0], got[0].memread}), int'({6'd0, 1'b1}));

    // randomized run against the reference model
    @(negedge clk); reset = 1'b1; #1;
    for (int k = 0; k < 3; k++) pidx[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 149) == 0);
      run       = ($urandom_range(0, 7) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) if (mstate(k) == 0) opc[k] = pick_op();
      #1;
      for (int k = 0; k < 3; k++) begin
        if (reset) pidx[k] = 0;
        model_check(k);
        if (!reset) model_step(k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
